// File: rtl/ebus_diag_reader.sv
// EBUS diagnostic read initiator: strobes a diag read function toward the datapath,
// waits for a settled EBUS word and returns it over a valid/ready response channel.
module ebus_diag_reader #(
    parameter int unsigned SETTLE    = 2,
    parameter int unsigned TIMEOUT   = 15,
    parameter logic [0:3]  DIAG_FUNC = 4'b0101
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [0:2]  reqSel,
    input  logic        reqAll,
    output logic [0:8]  diag,
    output logic        diagReadFunc12X,
    input  logic        drivingEBUS,
    input  logic [0:35] ebusIn,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [0:35] rspData,
    output logic [0:2]  rspSel,
    output logic        rspParity,
    output logic        rspTimeout,
    output logic        rspLast,
    output logic        busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_SETTLE, ST_RESP} state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
    localparam logic [3:0] ST_LIM = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [0:2]  sel_q, sel_d;
    logic        sweep_q, sweep_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [3:0]  scnt_q, scnt_d;
    logic [0:35] data_q, data_d;
    logic        par_q, par_d;
    logic        to_q, to_d;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            sweep_q <= 1'b0;
            tcnt_q  <= '0;
            scnt_q  <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            sweep_q <= sweep_d;
            tcnt_q  <= tcnt_d;
            scnt_q  <= scnt_d;
            data_q  <= data_d;
            par_q   <= par_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        sweep_d = sweep_q;
        tcnt_d  = tcnt_q;
        scnt_d  = scnt_q;
        data_d  = data_q;
        to_d    = to_q;
        unique case (state_q)
            ST_IDLE: begin
                if (reqValid) begin
                    sel_d   = reqAll ? 3'd0 : reqSel;
                    sweep_d = reqAll;
                    tcnt_d  = '0;
                    scnt_d  = '0;
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (drivingEBUS) begin
                    scnt_d = '0;
                    // The first driven cycle already counts toward the settle window.
                    if (ST_LIM == 4'd0) begin
                        data_d  = ebusIn;
                        to_d    = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                    if (tcnt_d == TO_LIM) begin
                        data_d  = '0;
                        to_d    = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_SETTLE: begin
                if (!drivingEBUS) begin
                    scnt_d  = '0;
                    state_d = ST_STROBE;
                end else begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_d == ST_LIM) begin
                        data_d  = ebusIn;
                        to_d    = 1'b0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rspReady) begin
                    if (sweep_q && (sel_q != 3'd7)) begin
                        sel_d   = sel_q + 3'd1;
                        tcnt_d  = '0;
                        state_d = ST_STROBE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        par_d = ^data_d;
    end

    assign reqReady        = (state_q == ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign diagReadFunc12X = (state_q == ST_STROBE) || (state_q == ST_SETTLE);
    assign diag            = diagReadFunc12X ? {DIAG_FUNC, sel_q, 2'b00} : 9'd0;
    assign rspValid        = (state_q == ST_RESP);
    assign rspData         = data_q;
    assign rspSel          = sel_q;
    assign rspParity       = par_q;
    assign rspTimeout      = to_q;
    assign rspLast         = rspValid && (!sweep_q || (sel_q == 3'd7));

endmodule

// File: tb/tb_ebus_diag_reader.sv
// Bench for ebus_diag_reader: directed scenarios plus random traffic, every cycle
// compared against a transaction-level reference of the read protocol.
module tb_ebus_diag_reader;

    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        resetN;
    logic        reqValid;
    logic        reqReady;
    logic [0:2]  reqSel;
    logic        reqAll;
    logic [0:8]  diag;
    logic        diagReadFunc12X;
    logic        drivingEBUS;
    logic [0:35] ebusIn;
    logic        rspValid;
    logic        rspReady;
    logic [0:35] rspData;
    logic [0:2]  rspSel;
    logic        rspParity;
    logic        rspTimeout;
    logic        rspLast;
    logic        busy;

    logic drv_en;

    ebus_diag_reader #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .DIAG_FUNC(4'b0101)) dut (
        .clk(clk), .resetN(resetN), .reqValid(reqValid), .reqReady(reqReady),
        .reqSel(reqSel), .reqAll(reqAll), .diag(diag), .diagReadFunc12X(diagReadFunc12X),
        .drivingEBUS(drivingEBUS), .ebusIn(ebusIn), .rspValid(rspValid), .rspReady(rspReady),
        .rspData(rspData), .rspSel(rspSel), .rspParity(rspParity), .rspTimeout(rspTimeout),
        .rspLast(rspLast), .busy(busy)
    );

    always #5 clk = ~clk;

    // The datapath answers the strobe combinationally, gated by the stimulus.
    assign drivingEBUS = diagReadFunc12X & drv_en;

    int n_vec = 0;
    int n_err = 0;

    // Reference: phase 0 idle, 1 strobing, 2 responding.
    int          e_phase;
    logic [2:0]  e_sel;
    logic        e_sweep;
    logic [35:0] e_data;
    logic        e_to;
    int          e_run;
    int          e_idle;
    logic        e_cnt;
    logic        model_ok = 1'b0;

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [8:0] exp_diag;
        exp_diag = (e_phase == 1) ? {4'b0101, e_sel, 2'b00} : 9'd0;
        chk("reqReady",   36'(reqReady),        36'(e_phase == 0));
        chk("busy",       36'(busy),            36'(e_phase != 0));
        chk("strobe",     36'(diagReadFunc12X), 36'(e_phase == 1));
        chk("diag",       36'(diag),            36'(exp_diag));
        chk("rspValid",   36'(rspValid),        36'(e_phase == 2));
        chk("rspData",    rspData,              e_data);
        chk("rspSel",     36'(rspSel),          36'(e_sel));
        chk("rspParity",  36'(rspParity),       36'(^e_data));
        chk("rspTimeout", 36'(rspTimeout),      36'(e_to));
        chk("rspLast",    36'(rspLast),         36'((e_phase == 2) && (!e_sweep || e_sel == 3'd7)));
    endtask

    task automatic start_read();
        e_phase = 1;
        e_run   = 0;
        e_idle  = 0;
        e_cnt   = 1'b1;
    endtask

    // Advance the reference by one clock using the inputs presented this cycle.
    task automatic model_next();
        if (!resetN) begin
            e_phase = 0; e_sel = 3'd0; e_sweep = 1'b0; e_data = '0; e_to = 1'b0;
            e_run = 0; e_idle = 0; e_cnt = 1'b1;
            model_ok = 1'b1;
            return;
        end
        if (!model_ok) return;
        case (e_phase)
            0: if (reqValid) begin
                e_sel   = reqAll ? 3'd0 : reqSel;
                e_sweep = reqAll;
                start_read();
            end
            1: if (drv_en) begin
                // A word is taken once the bus has been driven SETTLE cycles in a row.
                e_run++;
                e_cnt = 1'b0;
                if (e_run == SETTLE) begin
                    e_data = ebusIn; e_to = 1'b0; e_phase = 2;
                end
            end else begin
                // The cycle that breaks a driven run is not charged to the timeout.
                e_run = 0;
                if (e_cnt) begin
                    e_idle++;
                    if (e_idle == TIMEOUT) begin
                        e_data = '0; e_to = 1'b1; e_phase = 2;
                    end
                end
                e_cnt = 1'b1;
            end
            2: if (rspReady) begin
                if (e_sweep && e_sel != 3'd7) begin
                    e_sel = e_sel + 3'd1;
                    start_read();
                end else begin
                    e_phase = 0;
                end
            end
            default: e_phase = 0;
        endcase
    endtask

    task automatic step();
        #1;
        if (model_ok) check_outputs();
        model_next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic single(input logic [2:0] sel, input logic [35:0] data);
        reqValid = 1'b1; reqSel = sel; reqAll = 1'b0; drv_en = 1'b1;
        ebusIn = data; rspReady = 1'b1;
        step();
        reqValid = 1'b0;
        run(6);
    endtask

    initial begin
        resetN = 1'b0; reqValid = 1'b0; reqSel = '0; reqAll = 1'b0;
        drv_en = 1'b0; ebusIn = '0; rspReady = 1'b0;
        run(2);
        resetN = 1'b1;
        run(2);

        single(3'd3, 36'o123456701234);

        // Bus never driven: read must be abandoned after TIMEOUT strobe cycles.
        reqValid = 1'b1; reqSel = 3'd6; drv_en = 1'b0; rspReady = 1'b1;
        step();
        reqValid = 1'b0;
        run(TIMEOUT + 4);

        // Full sweep with a stalling consumer.
        reqValid = 1'b1; reqAll = 1'b1; drv_en = 1'b1;
        for (int i = 0; i < 120; i++) begin
            ebusIn   = 36'(e_sel) * 36'o010101010101;
            rspReady = i[0];
            step();
            reqValid = 1'b0;
            if (e_phase == 0 && i > 2) break;
        end
        reqAll = 1'b0;
        run(2);

        // One-cycle drop of drivingEBUS while settling.
        reqValid = 1'b1; reqSel = 3'd5; drv_en = 1'b1; ebusIn = 36'o111111111111; rspReady = 1'b1;
        step();
        reqValid = 1'b0;
        step();
        drv_en = 1'b0;
        step();
        drv_en = 1'b1; ebusIn = 36'o765432107654;
        run(5);

        // Reset while the third sweep read is settling.
        reqValid = 1'b1; reqAll = 1'b1; drv_en = 1'b1; rspReady = 1'b1; ebusIn = 36'o222222222222;
        for (int i = 0; i < 60; i++) begin
            if (e_phase == 1 && e_sel == 3'd2 && e_run == 1) break;
            step();
            reqValid = 1'b0;
        end
        resetN = 1'b0;
        step();
        resetN = 1'b1; reqAll = 1'b0;
        step();
        single(3'd1, 36'o707070707070);

        single(3'd2, 36'o000000000007);
        single(3'd4, 36'o000000000003);

        // Random traffic, mostly-driving bus with occasional resets.
        for (int i = 0; i < 400; i++) begin
            reqValid = 1'($urandom_range(0, 1));
            reqSel   = 3'($urandom);
            reqAll   = ($urandom_range(0, 5) == 0);
            drv_en   = ($urandom_range(0, 9) < 8);
            ebusIn   = {4'($urandom), 32'($urandom)};
            rspReady = ($urandom_range(0, 2) != 0);
            resetN   = ($urandom_range(0, 99) != 0);
            step();
        end
        resetN = 1'b1;
        // Sparse driving: exercises timeouts, including inside sweeps.
        for (int i = 0; i < 400; i++) begin
            reqValid = 1'($urandom_range(0, 1));
            reqSel   = 3'($urandom);
            reqAll   = ($urandom_range(0, 3) == 0);
            drv_en   = ($urandom_range(0, 9) < 2);
            ebusIn   = {4'($urandom), 32'($urandom)};
            rspReady = ($urandom_range(0, 1) != 0);
            step();
        end
        reqValid = 1'b0;
        rspReady = 1'b1;
        run(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
